uart_block_rx: RTL
==================

Name: uart_block_rx

Overview:
Serial front end for the DES engine. Receives 8N1 UART bytes on a single RX pin and assembles a 17-byte command frame: a header, an 8-byte key and an 8-byte data block. It presents the assembled 64-bit key, the 64-bit data and the encrypt/decrypt mode to the DES control path through a valid/accept handshake. It is the inbound counterpart of uart_send.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 9600, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be >= 4)
TIMEOUT_BITS, 40, inter-byte timeout in bit times (used only with RXBLK_TIMEOUT_EN)

Ports:
CLK_50MHZ  input  1  system clock; all logic on the rising edge
reset  input  1  asynchronous, active-low reset
rx  input  1  UART line, idle high, asynchronous to the clock
accept  input  1  DES side is idle and takes the block this cycle
block_valid  output  1  a complete frame is held on block_key/block_data/block_enc
block_key  output  64  key; the first key byte received is placed at [63:56]
block_data  output  64  plaintext/ciphertext; the first data byte received is placed at [63:56]
block_enc  output  1  1 = encrypt (header 0xE5), 0 = decrypt (header 0xD5)
frame_err  output  1  one-cycle pulse on a stop-bit error (or a timeout, see below)
overrun  output  1  one-cycle pulse when a byte is dropped in HOLD
busy  output  1  the frame FSM is in KEY or DATA

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, the key/data shadow registers 0, both FSMs in IDLE/HDR, the synchroniser at 1.
- rx passes through a 2-flop synchroniser that resets to 1. All decisions use the synchronised value.
- Bit FSM:
  - IDLE: on a synchronised 0, go to START and clear the counter.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If 0, go to DATA. If 1, it was a false start: return to IDLE with no pulses.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, into a shift register. Go to STOP after bit 7.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Sample 1: byte_done strobes for one cycle, then return to IDLE.
    - Sample 0: frame_err pulses, the byte is discarded and the frame FSM is forced to HDR. The FSM waits for rx=1 before IDLE.
- Frame FSM, driven by byte_done:
  - HDR: 0xE5 or 0xD5 latches the mode and moves to KEY with count=0. Any other byte is ignored and the FSM stays in HDR.
  - KEY: key_sh <= {key_sh[55:0], byte}. On the 8th byte (count==7) go to DATA with count=0.
  - DATA: same shifting into data_sh. On the 8th byte, copy key_sh, data_sh and mode onto block_key, block_data and block_enc, and go to HOLD.
  - HOLD: block_valid=1 with all outputs stable.
    - Transfer occurs on a cycle where block_valid=1 and accept=1. The next cycle has block_valid=0 and the FSM in HDR.
    - block_key, block_data and block_enc keep their values after transfer until the next frame completes.
    - A byte_done in HOLD drops the byte and pulses overrun; the FSM stays in HOLD. The bit FSM keeps receiving normally.
- Latency: block_valid rises exactly 1 cycle after the byte_done of the 16th payload byte.
- Simultaneous byte_done and accept in HOLD: the transfer wins, and the byte is dropped with an overrun pulse.
- Counter width is $clog2(CLKS_PER_BIT)+1; there is no wrap-around within a bit period.
- A reset in mid-byte or mid-frame aborts everything immediately. A line held low after reset is ignored until it returns high (the bit FSM requires a 1→0 edge after reset).

Optional Feature:
Macro RXBLK_TIMEOUT_EN.
- Defined: while the frame FSM is in KEY or DATA, a counter runs whenever the bit FSM is in IDLE and clears on any start detection. When it reaches TIMEOUT_BITS*CLKS_PER_BIT cycles, the partial frame is abandoned: the FSM returns to HDR, the shadow registers are cleared and frame_err pulses once.
- Not defined: there is no counter, and a partial frame waits indefinitely.

Test Plan (sim with CLK_FREQ=160, BAUD=10 → CLKS_PER_BIT=16):
- Send E5, key 68 75 6C 6C 6F 00 00 6E, data 48 65 6C 6C 6F 20 57 6F with accept=0 → block_valid=1 one cycle after the last byte_done; block_key=0x68756C6C6F00006E, block_data=0x48656C6C6F20576F, block_enc=1; raise accept for 1 cycle → block_valid=0 next cycle, outputs unchanged.
- Send D5 + key + data 16 2B 9D 97 95 76 71 F4 → block_enc=0, block_data=0x162B9D97957671F4; leading garbage bytes 00 and FF are ignored.
- Send byte 0x55 with the stop bit forced to 0 in the middle of the key → frame_err pulses once, busy=0; then a fresh full frame completes correctly.
- 6-cycle low glitch on rx while idle → no byte_done, no frame_err, FSMs unchanged.
- With block_valid held high (accept=0), send 0xA3 → overrun pulses once, block_data unchanged; accept=1 on the same cycle as a byte_done → transfer occurs and overrun pulses.
- RXBLK_TIMEOUT_EN defined: send E5 + 3 key bytes, then idle for 640 cycles → frame_err pulses at exactly 640 idle cycles, busy=0; without the macro, busy stays 1.

Source files
------------

// File: rtl/uart_block_rx.sv
// uart_block_rx: UART 8N1 receiver that assembles a 17-byte DES command frame
// (header 0xE5/0xD5, 8 key bytes, 8 data bytes) and holds the result for the
// DES control path behind a valid/accept handshake.
// Optional build macro RXBLK_TIMEOUT_EN: abandons a partial frame after
// TIMEOUT_BITS idle bit times.
//
// bit FSM   | meaning
// B_IDLE    | line idle, waiting for a falling edge (only once the line was seen high)
// B_START   | half a bit into the start bit, confirming it is still low
// B_DATA    | sampling 8 data bits, LSB first, one per bit period
// B_STOP    | sampling the stop bit
//
// frame FSM | meaning
// F_HDR     | waiting for a 0xE5 / 0xD5 header byte
// F_KEY     | collecting 8 key bytes
// F_DATA    | collecting 8 data bytes
// F_HOLD    | block presented, waiting for accept
module uart_block_rx #(
   parameter int CLK_FREQ     = 50000000,
   parameter int BAUD         = 9600,
   parameter int TIMEOUT_BITS = 40
) (
   input  logic        CLK_50MHZ,
   input  logic        reset,
   input  logic        rx,
   input  logic        accept,
   output logic        block_valid,
   output logic [63:0] block_key,
   output logic [63:0] block_data,
   output logic        block_enc,
   output logic        frame_err,
   output logic        overrun,
   output logic        busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CW           = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
   typedef enum logic [1:0] {F_HDR, F_KEY, F_DATA, F_HOLD} fstate_t;

   bstate_t       bstate;
   fstate_t       fstate;
   logic          rx_meta, rx_sync;
   logic [1:0]    sync_fill;
   logic          armed;
   logic [CW-1:0] bit_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          byte_done;
   logic          stop_err;
   logic [2:0]    byte_cnt;
   logic [63:0]   key_sh, data_sh;
   logic          mode;
   logic          to_fire;

   assign busy = (fstate == F_KEY) || (fstate == F_DATA);

   // Two-flop synchroniser; sync_fill marks when rx_sync holds a real line sample.
   always_ff @(posedge CLK_50MHZ or negedge reset) begin
      if (!reset) begin
         rx_meta   <= 1'b1;
         rx_sync   <= 1'b1;
         sync_fill <= 2'b00;
      end else begin
         rx_meta   <= rx;
         rx_sync   <= rx_meta;
         sync_fill <= {sync_fill[0], 1'b1};
      end
   end

   // Bit FSM: start detection, mid-bit sampling with a down-counter, stop check.
   always_ff @(posedge CLK_50MHZ or negedge reset) begin
      if (!reset) begin
         bstate    <= B_IDLE;
         armed     <= 1'b0;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         byte_done <= 1'b0;
         stop_err  <= 1'b0;
      end else begin
         byte_done <= 1'b0;
         stop_err  <= 1'b0;
         // Only a real high on the line arms start detection, so a line stuck
         // low after reset or after a framing error is not taken as a start.
         if (sync_fill[1] && rx_sync) armed <= 1'b1;
         case (bstate)
            B_IDLE: begin
               if (armed && !rx_sync) begin
                  bstate  <= B_START;
                  bit_cnt <= HALF_LAST;
               end
            end
            B_START: begin
               if (bit_cnt == '0) begin
                  if (!rx_sync) begin
                     bstate  <= B_DATA;
                     bit_cnt <= BIT_LAST;
                     bit_idx <= '0;
                  end else begin
                     bstate <= B_IDLE;
                  end
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            B_DATA: begin
               if (bit_cnt == '0) begin
                  shift   <= {rx_sync, shift[7:1]};
                  bit_cnt <= BIT_LAST;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) bstate <= B_STOP;
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            B_STOP: begin
               if (bit_cnt == '0) begin
                  bstate <= B_IDLE;
                  if (rx_sync) begin
                     byte_done <= 1'b1;
                  end else begin
                     stop_err <= 1'b1;
                     armed    <= 1'b0;
                  end
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            default: bstate <= B_IDLE;
         endcase
      end
   end

`ifdef RXBLK_TIMEOUT_EN
   localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW        = $clog2(TO_CYCLES) + 1;

   logic [TW-1:0] to_cnt;
   logic          to_run;

   assign to_run  = busy && (bstate == B_IDLE);
   assign to_fire = to_run && (to_cnt == '0);

   // Inter-byte timeout: counts idle line time inside a frame, reloads otherwise.
   always_ff @(posedge CLK_50MHZ or negedge reset) begin
      if (!reset)                to_cnt <= TW'(TO_CYCLES - 1);
      else if (!to_run || to_fire) to_cnt <= TW'(TO_CYCLES - 1);
      else                       to_cnt <= to_cnt - 1'b1;
   end
`else
   // No timeout in this build; TIMEOUT_BITS is non-negative so this is constant 0.
   assign to_fire = (TIMEOUT_BITS < 0);
`endif

   // Frame FSM: header decode, key/data assembly, hold and handshake.
   always_ff @(posedge CLK_50MHZ or negedge reset) begin
      if (!reset) begin
         fstate      <= F_HDR;
         byte_cnt    <= '0;
         key_sh      <= '0;
         data_sh     <= '0;
         mode        <= 1'b0;
         block_valid <= 1'b0;
         block_key   <= '0;
         block_data  <= '0;
         block_enc   <= 1'b0;
         frame_err   <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         overrun   <= 1'b0;
         frame_err <= stop_err || to_fire;
         case (fstate)
            F_HDR: begin
               if (byte_done && (shift == 8'hE5 || shift == 8'hD5)) begin
                  mode     <= (shift == 8'hE5);
                  byte_cnt <= '0;
                  fstate   <= F_KEY;
               end
            end
            F_KEY, F_DATA: begin
               if (stop_err || to_fire) begin
                  fstate <= F_HDR;
                  if (to_fire) begin
                     key_sh  <= '0;
                     data_sh <= '0;
                  end
               end else if (byte_done) begin
                  byte_cnt <= byte_cnt + 3'd1;
                  if (fstate == F_KEY) begin
                     key_sh <= {key_sh[55:0], shift};
                     if (byte_cnt == 3'd7) begin
                        byte_cnt <= '0;
                        fstate   <= F_DATA;
                     end
                  end else begin
                     data_sh <= {data_sh[55:0], shift};
                     if (byte_cnt == 3'd7) begin
                        block_key   <= key_sh;
                        block_data  <= {data_sh[55:0], shift};
                        block_enc   <= mode;
                        block_valid <= 1'b1;
                        fstate      <= F_HOLD;
                     end
                  end
               end
            end
            F_HOLD: begin
               // A held block survives line errors; a new byte here is lost.
               if (byte_done) overrun <= 1'b1;
               if (accept) begin
                  block_valid <= 1'b0;
                  fstate      <= F_HDR;
               end
            end
            default: fstate <= F_HDR;
         endcase
      end
   end

endmodule
